// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 packet router data path.
// Header byte layout: [7:2] payload length, [1:0] output address.
package router_pkg;

  localparam int DATA_W = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef struct packed {
    logic [5:0] len;
    logic [1:0] addr;
  } hdr_t;

  function automatic logic addr_ok(input hdr_t h);
    return h.addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, compared against the
// trailing parity byte once parity_done is up.
module router_parity_chk
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              full_state,
  input  logic              pkt_valid,
  input  logic              parity_done,
  input  logic [DATA_W-1:0] header_byte,
  input  logic [DATA_W-1:0] data_in,
  output logic              err
);

  logic [DATA_W-1:0] int_parity;
  logic [DATA_W-1:0] pkt_parity;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      int_parity <= '0;
      pkt_parity <= '0;
      err        <= 1'b0;
    end else begin
      if (detect_add)
        int_parity <= '0;
      else if (lfd_state)
        int_parity <= int_parity ^ header_byte;
      else if (ld_state && pkt_valid && !full_state)
        int_parity <= int_parity ^ data_in;

      if (detect_add)
        pkt_parity <= '0;
      else if (ld_state && !pkt_valid)
        pkt_parity <= data_in;

      // re-evaluated every cycle so err tracks the captured bytes
      if (detect_add)
        err <= 1'b0;
      else if (parity_done)
        err <= (int_parity != pkt_parity);
    end
  end

endmodule

// File: rtl/router_register.sv
// Router data-path register: header latch, FIFO write byte, full hold.
// Parity checking is built only when ROUTER_REG_PARITY_CHECK_EN is defined.
module router_register
  import router_pkg::*;
(
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic              parity_done,
  output logic              low_packet_valid
);

  hdr_t              hdr_in;
  hdr_t              header_byte;
  logic [DATA_W-1:0] fsb;

  assign hdr_in = data_in;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      header_byte <= '0;
    else if (detect_add && pkt_valid && addr_ok(hdr_in))
      header_byte <= hdr_in;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout <= '0;
      fsb  <= '0;
    end else begin
      if (lfd_state)
        dout <= header_byte;
      else if (ld_state && !fifo_full)
        dout <= data_in;
      else if (laf_state)
        dout <= fsb;

      // byte arriving while the FIFO is full is parked until laf_state
      if (ld_state && fifo_full)
        fsb <= data_in;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      parity_done      <= 1'b0;
      low_packet_valid <= 1'b0;
    end else begin
      if (detect_add)
        parity_done <= 1'b0;
      else if (ld_state && !fifo_full && !pkt_valid)
        parity_done <= 1'b1;
      else if (laf_state && low_packet_valid && !parity_done)
        parity_done <= 1'b1;

      if (rst_int_reg)
        low_packet_valid <= 1'b0;
      else if (ld_state && !pkt_valid)
        low_packet_valid <= 1'b1;
    end
  end

`ifdef ROUTER_REG_PARITY_CHECK_EN
  router_parity_chk u_parity_chk (
    .clock       (clock),
    .resetn      (resetn),
    .detect_add  (detect_add),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .full_state  (full_state),
    .pkt_valid   (pkt_valid),
    .parity_done (parity_done),
    .header_byte (header_byte),
    .data_in     (data_in),
    .err         (err)
  );
`else
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_register.sv
// Directed + randomized bench for router_register with a packet-level model.
// Expected bytes come from a queue of bytes the FIFO should have received.
module tb_router_register;
  import router_pkg::*;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid, fifo_full, detect_add, lfd_state;
  logic       ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] data_in;
  logic [7:0] dout;
  logic       err, parity_done, low_packet_valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] written[$];
  logic [7:0] last_hdr;

  router_register dut (
    .clock            (clock),
    .resetn           (resetn),
    .pkt_valid        (pkt_valid),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .data_in          (data_in),
    .dout             (dout),
    .err              (err),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    pkt_valid   = 1'b0;
    fifo_full   = 1'b0;
    detect_add  = 1'b0;
    lfd_state   = 1'b0;
    ld_state    = 1'b0;
    laf_state   = 1'b0;
    full_state  = 1'b0;
    rst_int_reg = 1'b0;
    data_in     = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic exp_err(input logic [7:0] calc,
                                   input logic [7:0] par);
`ifdef ROUTER_REG_PARITY_CHECK_EN
    return calc != par;
`else
    return 1'b0;
`endif
  endfunction

  // FIFO-full detour: full_state wait, then laf_state flushes the held byte
  task automatic drain(input logic [7:0] held);
    idle();
    full_state = 1'b1;
    fifo_full  = 1'b1;
    pkt_valid  = 1'($urandom);
    tick();
    chk("full_hold", dout, written[$]);
    idle();
    laf_state = 1'b1;
    pkt_valid = 1'b1;
    tick();
    written.push_back(held);
    chk("laf_dout", dout, held);
  endtask

  task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[$],
                          input logic [7:0] par, input logic [63:0] stall,
                          input bit int_lock);
    logic [7:0] calc;
    logic       e;
    int         n;
    n = pl.size();
    idle();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = hdr;
    tick();
    chk("da_pd_clr", parity_done, 8'h00);
    chk("da_err_clr", err, 8'h00);
    if (hdr[1:0] != 2'b11) last_hdr = hdr;
    idle();
    lfd_state = 1'b1;
    pkt_valid = 1'b1;
    tick();
    written.push_back(last_hdr);
    chk("lfd_dout", dout, last_hdr);
    calc = last_hdr;
    for (int i = 0; i < n; i++) begin
      idle();
      ld_state  = 1'b1;
      pkt_valid = 1'b1;
      fifo_full = stall[i];
      data_in   = pl[i];
      tick();
      calc ^= pl[i];
      if (stall[i]) begin
        chk("ld_full_hold", dout, written[$]);
        drain(pl[i]);
      end else begin
        written.push_back(pl[i]);
        chk("ld_dout", dout, pl[i]);
      end
    end
    idle();
    ld_state    = 1'b1;
    fifo_full   = stall[n];
    rst_int_reg = int_lock;
    data_in     = par;
    tick();
    chk("lpv_set", low_packet_valid, {7'd0, !int_lock});
    if (stall[n]) begin
      chk("par_full_pd", parity_done, 8'h00);
      chk("par_full_hold", dout, written[$]);
      drain(par);
    end else begin
      written.push_back(par);
      chk("par_dout", dout, par);
    end
    chk("pd_set", parity_done, 8'h01);
    chk("err_early", err, 8'h00);
    e = exp_err(calc, par);
    idle();
    rst_int_reg = 1'b1;
    tick();
    chk("err_val", err, {7'd0, e});
    chk("lpv_clr", low_packet_valid, 8'h00);
    idle();
    tick();
    chk("err_hold", err, {7'd0, e});
    chk("pd_hold", parity_done, 8'h01);
  endtask

  initial begin
    logic [7:0] pl[$];
    logic [7:0] h;
    logic [7:0] p;
    logic [63:0] st;
    int len;

    idle();
    last_hdr = 8'h00;
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_dout", dout, 8'h00);
    chk("rst_err", err, 8'h00);
    chk("rst_pd", parity_done, 8'h00);
    chk("rst_lpv", low_packet_valid, 8'h00);
    resetn = 1'b1;
    tick();

    pl = '{8'h11, 8'h22, 8'h33};
    send_pkt(8'h0D, pl, 8'h0D, 64'd0, 1'b0);
    send_pkt(8'h0D, pl, 8'hF2, 64'd0, 1'b0);

    pl = '{8'hA5, 8'h3C};
    send_pkt(8'h0A, pl, 8'h99, 64'b001, 1'b0);
    send_pkt(8'h0A, pl, 8'h99, 64'b100, 1'b0);

    idle();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = 8'h0F;
    tick();
    idle();
    lfd_state = 1'b1;
    tick();
    chk("inv_addr_hdr", dout, last_hdr);

    pl = '{8'h5A};
    send_pkt(8'h06, pl, 8'h00, 64'd0, 1'b1);

    for (int k = 0; k < 20; k++) begin
      len = $urandom_range(1, 8);
      h = {6'(len), 2'($urandom_range(0, 2))};
      pl.delete();
      p = h;
      for (int i = 0; i < len; i++) begin
        pl.push_back(8'($urandom));
        p ^= pl[i];
      end
      if ($urandom_range(0, 1) == 1)
        p ^= 8'($urandom_range(1, 255));
      st = '0;
      for (int i = 0; i <= len; i++)
        st[i] = ($urandom_range(0, 3) == 0);
      send_pkt(h, pl, p, st, 1'b0);
    end

    idle();
    detect_add = 1'b1;
    pkt_valid  = 1'b1;
    data_in    = 8'h09;
    tick();
    idle();
    lfd_state = 1'b1;
    tick();
    idle();
    ld_state  = 1'b1;
    pkt_valid = 1'b0;
    data_in   = 8'h81;
    tick();
    chk("pre_rst_dout", dout, 8'h81);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_rst_dout", dout, 8'h00);
    chk("async_rst_pd", parity_done, 8'h00);
    chk("async_rst_lpv", low_packet_valid, 8'h00);
    chk("async_rst_err", err, 8'h00);
    tick();
    resetn = 1'b1;
    last_hdr = 8'h00;
    written.delete();
    tick();

    pl = '{8'h01, 8'h80};
    send_pkt(8'h0A, pl, 8'h8B, 64'b010, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
